// File: rtl/wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : wb_register_file
// Function : Writeback select, 32-entry GPR file with two async read ports,
//            forwarding tap and retired-write counter.
//            Optional same-cycle write-before-read bypass: define WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_read_data_buffered,
    input  logic [DATA_WIDTH-1:0] alu_result_buffered,
    input  logic [ADDR_WIDTH-1:0] write_reg_addr_buffered,
    input  logic                  reg_write_buffered,
    input  logic                  mem_reg_buffered,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_valid,
    output logic [31:0]           retired_writes
);

    localparam int                  c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = '0;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic [31:0]           r_retired_writes;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_stored_a;
    logic [DATA_WIDTH-1:0] w_stored_b;

    assign w_wb_data = mem_reg_buffered ? mem_read_data_buffered : alu_result_buffered;
    assign w_commit  = reg_write_buffered && (write_reg_addr_buffered != c_ZERO_ADDR) && !rst;

    // Entry 0 is only ever written by reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_retired_writes <= '0;
        end else if (w_commit) begin
            r_regs[write_reg_addr_buffered] <= w_wb_data;
            r_retired_writes                <= r_retired_writes + 32'd1;
        end
    end

    assign w_stored_a = (read_addr_a == c_ZERO_ADDR) ? '0 : r_regs[read_addr_a];
    assign w_stored_b = (read_addr_b == c_ZERO_ADDR) ? '0 : r_regs[read_addr_b];

`ifdef WB_BYPASS_EN
    // w_commit already excludes address 0, so r0 is never bypassed.
    assign read_data_a = (w_commit && read_addr_a == write_reg_addr_buffered) ? w_wb_data : w_stored_a;
    assign read_data_b = (w_commit && read_addr_b == write_reg_addr_buffered) ? w_wb_data : w_stored_b;
`else
    assign read_data_a = w_stored_a;
    assign read_data_b = w_stored_b;
`endif

    assign wb_data        = w_wb_data;
    assign wb_valid       = w_commit;
    assign retired_writes = r_retired_writes;

endmodule
`default_nettype wire

// File: tb/tb_wb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_register_file
// Function : Table-driven self-checking bench for wb_register_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_register_file;

`ifdef WB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_read_data_buffered;
    logic [31:0] alu_result_buffered;
    logic [4:0]  write_reg_addr_buffered;
    logic        reg_write_buffered;
    logic        mem_reg_buffered;
    logic [4:0]  read_addr_a;
    logic [4:0]  read_addr_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] retired_writes;

    always #5 clk = ~clk;

    wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_read_data_buffered  (mem_read_data_buffered),
        .alu_result_buffered     (alu_result_buffered),
        .write_reg_addr_buffered (write_reg_addr_buffered),
        .reg_write_buffered      (reg_write_buffered),
        .mem_reg_buffered        (mem_reg_buffered),
        .read_addr_a             (read_addr_a),
        .read_addr_b             (read_addr_b),
        .read_data_a             (read_data_a),
        .read_data_b             (read_data_b),
        .wb_data                 (wb_data),
        .wb_valid                (wb_valid),
        .retired_writes          (retired_writes)
    );

    typedef struct {
        logic [31:0] wb;
        logic        valid;
        logic [31:0] pre_a;
        logic [31:0] pre_b;
        logic [31:0] post_a;
        logic [31:0] post_b;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic        mem_reg;
        logic [4:0]  waddr;
        logic [31:0] mem_data;
        logic [31:0] alu;
        logic [4:0]  ra;
        logic [4:0]  rb;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic we, input logic mr, input logic [4:0] wa,
                       input logic [31:0] md, input logic [31:0] al,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] ewb, input logic ev,
                       input logic [31:0] pa, input logic [31:0] pb,
                       input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.we = we; v.mem_reg = mr; v.waddr = wa; v.mem_data = md; v.alu = al;
        v.ra = ra; v.rb = rb;
        v.e.wb = ewb; v.e.valid = ev; v.e.pre_a = pa; v.e.pre_b = pb;
        v.e.post_a = qa; v.e.post_b = qb; v.e.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic we, input logic mr, input logic [4:0] wa,
                         input logic [31:0] md, input logic [31:0] al,
                         input logic [4:0] ra, input logic [4:0] rb);
        rst = r; reg_write_buffered = we; mem_reg_buffered = mr;
        write_reg_addr_buffered = wa; mem_read_data_buffered = md;
        alu_result_buffered = al; read_addr_a = ra; read_addr_b = rb;
    endtask

    initial begin
        logic [31:0] s_wb, s_pa, s_pb;
        logic        s_v;
        exp_t        e;

        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cnt", retired_writes, 32'h0);
        chk("reset_rd_a", read_data_a, 32'h0);
        chk("reset_valid", {31'b0, wb_valid}, 32'h0);

        //   rst we mr wa     mem_data      alu           ra     rb     wb            v  pre_a  pre_b  post_a post_b cnt
        add(0, 1, 0, 5'd5,  32'h0,        32'h1234,     5'd5,  5'd0,  32'h1234,     1,
            c_BYP ? 32'h1234 : 32'h0, 32'h0, 32'h1234, 32'h0, 1);
        add(1, 0, 1, 5'd5,  32'h88,       32'h77,       5'd5,  5'd0,  32'h88,       0,
            32'h1234, 32'h0, 32'h0, 32'h0, 0);
        add(0, 1, 1, 5'd7,  32'hDEADBEEF, 32'h11111111, 5'd7,  5'd5,  32'hDEADBEEF, 1,
            c_BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 1);
        add(0, 1, 0, 5'd7,  32'hDEADBEEF, 32'h11111111, 5'd7,  5'd7,  32'h11111111, 1,
            c_BYP ? 32'h11111111 : 32'hDEADBEEF, c_BYP ? 32'h11111111 : 32'hDEADBEEF,
            32'h11111111, 32'h11111111, 2);
        add(0, 1, 0, 5'd0,  32'h0,        32'hFFFFFFFF, 5'd0,  5'd7,  32'hFFFFFFFF, 0,
            32'h0, 32'h11111111, 32'h0, 32'h11111111, 2);
        add(0, 1, 0, 5'd3,  32'h0,        32'hA,        5'd3,  5'd0,  32'hA,        1,
            c_BYP ? 32'hA : 32'h0, 32'h0, 32'hA, 32'h0, 3);
        add(0, 1, 1, 5'd3,  32'hB,        32'hC,        5'd3,  5'd3,  32'hB,        1,
            c_BYP ? 32'hB : 32'hA, c_BYP ? 32'hB : 32'hA, 32'hB, 32'hB, 4);
        add(1, 1, 0, 5'd9,  32'h0,        32'h55,       5'd9,  5'd3,  32'h55,       0,
            32'h0, 32'hB, 32'h0, 32'h0, 0);
        add(0, 0, 0, 5'd9,  32'h0,        32'h66,       5'd9,  5'd7,  32'h66,       0,
            32'h0, 32'h0, 32'h0, 32'h0, 0);
        add(0, 1, 0, 5'd31, 32'h0,        32'h80000001, 5'd31, 5'd30, 32'h80000001, 1,
            c_BYP ? 32'h80000001 : 32'h0, 32'h0, 32'h80000001, 32'h0, 1);
        add(0, 1, 1, 5'd30, 32'hCAFEF00D, 32'h3,        5'd31, 5'd30, 32'hCAFEF00D, 1,
            32'h80000001, c_BYP ? 32'hCAFEF00D : 32'h0, 32'h80000001, 32'hCAFEF00D, 2);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].mem_reg, vecs[i].waddr,
                  vecs[i].mem_data, vecs[i].alu, vecs[i].ra, vecs[i].rb);
            sb.push_back(vecs[i].e);
            #1;
            s_wb = wb_data; s_v = wb_valid; s_pa = read_data_a; s_pb = read_data_b;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_wb_data", i), s_wb, e.wb);
            chk($sformatf("v%0d_wb_valid", i), {31'b0, s_v}, {31'b0, e.valid});
            chk($sformatf("v%0d_pre_a", i), s_pa, e.pre_a);
            chk($sformatf("v%0d_pre_b", i), s_pb, e.pre_b);
            chk($sformatf("v%0d_post_a", i), read_data_a, e.post_a);
            chk($sformatf("v%0d_post_b", i), read_data_b, e.post_b);
            chk($sformatf("v%0d_count", i), retired_writes, e.cnt);
        end

        // Counter wrap: preset the count through a backdoor, then commit twice.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd1, 32'h0, 32'h1, 5'd1, 5'd0);
        force dut.r_retired_writes = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_writes;
        #1;
        chk("wrap_preset", retired_writes, 32'hFFFF_FFFF);
        reg_write_buffered = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_to_zero", retired_writes, 32'h0);
        chk("wrap_data", read_data_a, 32'h1);
        @(posedge clk);
        #1;
        chk("wrap_plus_one", retired_writes, 32'h1);
        @(negedge clk);
        reg_write_buffered = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
